// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with load-use hazard detection,
// branch flush and a saturating count of the bubbles inserted for load-use.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs2,
  input  logic             id_regwr,
  input  logic             id_memread,
  input  logic             id_memwr,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             flush,
  output logic             stall,
  output logic             ID_EX_valid,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [4:0]       ID_EX_rs1,
  output logic [4:0]       ID_EX_rs2,
  output logic [4:0]       ID_EX_rd,
  output logic             ID_EX_regwr,
  output logic             ID_EX_memread,
  output logic             ID_EX_memwr,
  output logic             ID_EX_memtoreg,
  output logic             ID_EX_alusrc,
  output logic [1:0]       ID_EX_aluop,
  output logic [2:0]       ID_EX_funct3,
  output logic             ID_EX_funct7b5,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwr;
    logic            memread;
    logic            memwr;
    logic            memtoreg;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic            funct7b5;
  } id_ex_t;

  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;

  // Load in EX whose destination the instruction in ID needs: forwarding cannot cover it.
  always_comb begin
    hz = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
         ((ex_q.rd == id_rs1) | (id_uses_rs2 & (ex_q.rd == id_rs2)));
    stall = hz & ~flush;
  end

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hz) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      // An invalid slot may carry stale decode; its side-effecting controls are masked.
      ex_d.regwr    = id_regwr    & id_valid;
      ex_d.memread  = id_memread  & id_valid;
      ex_d.memwr    = id_memwr    & id_valid;
      ex_d.memtoreg = id_memtoreg & id_valid;
      ex_d.alusrc   = id_alusrc;
      ex_d.aluop    = id_aluop;
      ex_d.funct3   = id_funct3;
      ex_d.funct7b5 = id_funct7b5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ID_EX_valid    = ex_q.valid;
  assign ID_EX_pc       = ex_q.pc;
  assign ID_EX_rs1_data = ex_q.rs1_data;
  assign ID_EX_rs2_data = ex_q.rs2_data;
  assign ID_EX_imm      = ex_q.imm;
  assign ID_EX_rs1      = ex_q.rs1;
  assign ID_EX_rs2      = ex_q.rs2;
  assign ID_EX_rd       = ex_q.rd;
  assign ID_EX_regwr    = ex_q.regwr;
  assign ID_EX_memread  = ex_q.memread;
  assign ID_EX_memwr    = ex_q.memwr;
  assign ID_EX_memtoreg = ex_q.memtoreg;
  assign ID_EX_alusrc   = ex_q.alusrc;
  assign ID_EX_aluop    = ex_q.aluop;
  assign ID_EX_funct3   = ex_q.funct3;
  assign ID_EX_funct7b5 = ex_q.funct7b5;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset corner cases, then
// random traffic against a reference model of the ID/EX register.
module tb_id_ex_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs2, id_regwr, id_memread, id_memwr, id_memtoreg, id_alusrc, id_funct7b5, flush;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_aluop;
  logic [2:0] id_funct3;
  logic stall, ID_EX_valid, ID_EX_regwr, ID_EX_memread, ID_EX_memwr, ID_EX_memtoreg, ID_EX_alusrc, ID_EX_funct7b5;
  logic [XLEN-1:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [1:0] ID_EX_aluop;
  logic [2:0] ID_EX_funct3;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
    .id_regwr(id_regwr), .id_memread(id_memread), .id_memwr(id_memwr),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush(flush), .stall(stall),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
    .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1),
    .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd), .ID_EX_regwr(ID_EX_regwr),
    .ID_EX_memread(ID_EX_memread), .ID_EX_memwr(ID_EX_memwr),
    .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_alusrc(ID_EX_alusrc),
    .ID_EX_aluop(ID_EX_aluop), .ID_EX_funct3(ID_EX_funct3),
    .ID_EX_funct7b5(ID_EX_funct7b5), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle, the stall seen in that cycle,
  // and a subset of the ID/EX outputs after the following edge.
  typedef struct {
    logic v; logic [31:0] pc; logic [4:0] rs1, rs2, rd; logic u2, rw, mr, fl;
    logic st, ev; logic [4:0] erd, ers1; logic [31:0] epc; logic erw; logic [CNT_W-1:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic push(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                      input logic u2, rw, mr, fl, input logic st, ev, input logic [4:0] erd, ers1,
                      input logic [31:0] epc, input logic erw, input int cnt);
    vec_t t;
    t.v = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u2 = u2; t.rw = rw; t.mr = mr; t.fl = fl;
    t.st = st; t.ev = ev; t.erd = erd; t.ers1 = ers1; t.epc = epc; t.erw = erw; t.cnt = CNT_W'(cnt);
    tbl.push_back(t);
  endtask

  // Reference model of the register contents, kept as a plain record.
  typedef struct {
    logic valid; logic [31:0] pc, d1, d2, imm; logic [4:0] rs1, rs2, rd;
    logic regwr, memread, memwr, memtoreg, alusrc; logic [1:0] aluop; logic [2:0] f3; logic f7;
    int cnt;
  } mdl_t;
  mdl_t m, m_nx;

  function automatic logic [191:0] dut_vec();
    return 192'({ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1,
                 ID_EX_rs2, ID_EX_rd, ID_EX_regwr, ID_EX_memread, ID_EX_memwr, ID_EX_memtoreg,
                 ID_EX_alusrc, ID_EX_aluop, ID_EX_funct3, ID_EX_funct7b5, bubble_cnt});
  endfunction

  function automatic logic [191:0] mdl_vec(input mdl_t x);
    logic [CNT_W-1:0] c;
    c = CNT_W'(x.cnt);
    return 192'({x.valid, x.pc, x.d1, x.d2, x.imm, x.rs1, x.rs2, x.rd, x.regwr, x.memread,
                 x.memwr, x.memtoreg, x.alusrc, x.aluop, x.f3, x.f7, c});
  endfunction

  function automatic mdl_t mdl_clear(input int cnt);
    mdl_t z;
    z = '{default: '0};
    z.cnt = cnt;
    return z;
  endfunction

  function automatic logic mdl_hazard(input mdl_t x);
    if (!(id_valid && x.valid && x.memread) || x.rd == 5'd0) return 1'b0;
    return (x.rd == id_rs1) || (id_uses_rs2 && x.rd == id_rs2);
  endfunction

  function automatic mdl_t mdl_next(input mdl_t x);
    mdl_t n;
    if (flush) return mdl_clear(x.cnt);
    if (mdl_hazard(x)) return mdl_clear((x.cnt < int'(CMAX)) ? x.cnt + 1 : x.cnt);
    n.valid = id_valid; n.pc = id_pc; n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
    n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
    n.regwr = id_regwr && id_valid; n.memread = id_memread && id_valid;
    n.memwr = id_memwr && id_valid; n.memtoreg = id_memtoreg && id_valid;
    n.alusrc = id_alusrc; n.aluop = id_aluop; n.f3 = id_funct3; n.f7 = id_funct7b5;
    n.cnt = x.cnt;
    return n;
  endfunction

  task automatic drive_vec(input vec_t t);
    id_valid = t.v; id_pc = t.pc; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_uses_rs2 = t.u2; id_regwr = t.rw; id_memread = t.mr; id_memtoreg = t.mr; id_memwr = 1'b0;
    id_alusrc = t.mr; id_aluop = t.mr ? 2'd0 : 2'd2; id_funct3 = t.mr ? 3'd2 : 3'd0; id_funct7b5 = 1'b0;
    id_rs1_data = t.pc + 32'd1; id_rs2_data = t.pc + 32'd2; id_imm = t.pc + 32'd3; flush = t.fl;
  endtask

  task automatic drive_rand();
    id_valid = ($urandom_range(0, 7) != 0); id_pc = $urandom; id_rs1_data = $urandom;
    id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
    id_uses_rs2 = 1'($urandom); id_regwr = 1'($urandom); id_memread = 1'($urandom);
    id_memwr = 1'($urandom); id_memtoreg = 1'($urandom); id_alusrc = 1'($urandom);
    id_aluop = 2'($urandom); id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    logic prev_stall;
    vec_t zero_v;
    zero_v = '{default: '0};
    rst = 1'b1;
    drive_vec(zero_v);
    #2;
    chk("reset_state", dut_vec(), 192'd0);
    chk("reset_stall", 192'(stall), 192'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pass-through, load-use, no-stall cases, flush precedence, invalid slot.
    push(1, 32'h10, 1, 2, 3, 1, 1, 0, 0,  0, 1, 3, 1, 32'h10, 1, 0);
    push(1, 32'h14, 1, 0, 5, 0, 1, 1, 0,  0, 1, 5, 1, 32'h14, 1, 0);
    push(1, 32'h18, 5, 7, 6, 1, 1, 0, 0,  1, 0, 0, 0, 32'h00, 0, 1);
    push(1, 32'h18, 5, 7, 6, 1, 1, 0, 0,  0, 1, 6, 5, 32'h18, 1, 1);
    push(1, 32'h1c, 1, 0, 0, 0, 1, 1, 0,  0, 1, 0, 1, 32'h1c, 1, 1);
    push(1, 32'h20, 0, 7, 6, 1, 1, 0, 0,  0, 1, 6, 0, 32'h20, 1, 1);
    push(1, 32'h24, 1, 0, 5, 0, 1, 1, 0,  0, 1, 5, 1, 32'h24, 1, 1);
    push(1, 32'h28, 8, 5, 6, 0, 1, 0, 0,  0, 1, 6, 8, 32'h28, 1, 1);
    push(1, 32'h2c, 1, 0, 5, 0, 1, 1, 0,  0, 1, 5, 1, 32'h2c, 1, 1);
    push(1, 32'h30, 5, 7, 6, 1, 1, 0, 1,  0, 0, 0, 0, 32'h00, 0, 1);
    push(0, 32'h34, 2, 0, 9, 0, 1, 1, 0,  0, 0, 9, 2, 32'h34, 0, 1);
    push(1, 32'h38, 9, 9, 10, 1, 1, 0, 0, 0, 1, 10, 9, 32'h38, 1, 1);
    // Four more load-use pairs drive the 2-bit counter into saturation.
    for (int k = 0; k < 4; k++) begin
      int c;
      logic [31:0] p;
      c = (k + 1 < int'(CMAX)) ? k + 1 : int'(CMAX);
      p = 32'h40 + 32'(k * 8);
      push(1, p,     1, 0, 5, 0, 1, 1, 0, 0, 1, 5, 1, p,     1, c);
      push(1, p + 4, 5, 7, 6, 1, 1, 0, 0, 1, 0, 0, 0, 32'h0, 0, (c < int'(CMAX)) ? c + 1 : c);
      push(1, p + 4, 5, 7, 6, 1, 1, 0, 0, 0, 1, 6, 5, p + 4, 1, (c < int'(CMAX)) ? c + 1 : c);
    end

    foreach (tbl[i]) begin
      drive_vec(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 192'(stall), 192'(tbl[i].st));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i),
          192'({ID_EX_valid, ID_EX_rd, ID_EX_rs1, ID_EX_pc, ID_EX_regwr, bubble_cnt}),
          192'({tbl[i].ev, tbl[i].erd, tbl[i].ers1, tbl[i].epc, tbl[i].erw, tbl[i].cnt}));
    end

    // Reset asserted mid-cycle during a load-use stall.
    drive_vec(tbl[1]);
    @(posedge clk); #1;
    drive_vec(tbl[2]);
    @(negedge clk);
    chk("pre_reset_stall", 192'(stall), 192'd1);
    #1 rst = 1'b1;
    #1;
    chk("midreset_out", dut_vec(), 192'd0);
    chk("midreset_stall", 192'(stall), 192'd0);
    @(negedge clk);
    rst = 1'b0;
    m = mdl_clear(0);

    // Random traffic; a stalled instruction is usually re-presented like real upstream.
    prev_stall = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!(prev_stall && $urandom_range(0, 3) != 0)) drive_rand();
      #1;
      m_nx = mdl_next(m);
      prev_stall = mdl_hazard(m) && !flush;
      chk("rand_stall", 192'(stall), 192'(prev_stall));
      @(posedge clk); #1;
      m = m_nx;
      chk("rand_out", dut_vec(), mdl_vec(m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core, sitting between decode and execute.
- Registers decoded operands and control from ID and presents `ID_EX_*` fields to the forwarding unit and the ALU.
- Contains load-use hazard detection: stalls IF/ID and injects a bubble when forwarding cannot cover a dependency.
- Honours a branch flush from EX/MEM.
- Keeps a saturating count of injected load-use bubbles for performance debug.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNT_W`, 16, width of bubble counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  XLEN  instruction PC
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data
- `id_imm`  in  XLEN  sign-extended immediate
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices
- `id_uses_rs2`  in  1  instruction reads rs2 (R/S/B types)
- `id_regwr`, `id_memread`, `id_memwr`, `id_memtoreg`, `id_alusrc`  in  1 each  decoded controls
- `id_aluop`  in  2  ALU op class
- `id_funct3`  in  3  funct3
- `id_funct7b5`  in  1  instruction bit 30
- `flush`  in  1  branch/jump taken, kill ID and ID/EX contents
- `stall`  out  1  combinational; hold PC and IF/ID this cycle
- `ID_EX_valid`  out  1  registered valid
- `ID_EX_pc`, `ID_EX_rs1_data`, `ID_EX_rs2_data`, `ID_EX_imm`  out  XLEN  registered
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd`  out  5  registered, feed forwarding unit
- `ID_EX_regwr`, `ID_EX_memread`, `ID_EX_memwr`, `ID_EX_memtoreg`, `ID_EX_alusrc`  out  1 each  registered
- `ID_EX_aluop`  out 2; `ID_EX_funct3`  out 3; `ID_EX_funct7b5`  out 1  registered
- `bubble_cnt`  out  CNT_W  load-use bubbles inserted since reset, saturating

## Operation
- Hazard (combinational): `hz = id_valid & ID_EX_valid & ID_EX_memread & (ID_EX_rd != 0) & ((ID_EX_rd == id_rs1) | (id_uses_rs2 & (ID_EX_rd == id_rs2)))`.
- `stall = hz & ~flush`. Flush kills the ID instruction, so no stall is needed.
- Per-edge update, priority order:
  1. **Flush:** load a bubble.
  2. **Stall:** load a bubble. `bubble_cnt` increments unless it equals all-ones.
  3. **Otherwise (normal):** load every `id_*` field, and set `ID_EX_valid = id_valid`.
- Bubble definition: all `ID_EX_*` outputs become 0, including the data fields, rs1/rs2/rd, and `ID_EX_valid`. A zero rd with zero regwr/memwr guarantees no architectural effect and no false forwarding match.
- When `id_valid=0` in the normal case, the fields still load, but the control bits (regwr, memread, memwr, memtoreg) are forced to 0.
- Effect of the stall: the instruction in ID is re-presented next cycle, because the upstream holds. By then ID/EX holds the bubble (memread=0), so the stall lasts exactly one cycle per load-use pair.

## Timing
- Reset (async assert, sync-released by the top level): every `ID_EX_*` output is 0, `bubble_cnt` is 0, and `stall` is 0. The registers are cleared immediately on `rst` rising, without waiting for `clk`.
- ID to ID/EX latency: 1 cycle.
- `stall` is valid in the same cycle as its inputs. No registered stall state exists.
- `flush` and `hz` in the same cycle: bubble loaded, `stall=0`, `bubble_cnt` unchanged.
- Load to rd=x0 never stalls.
- A non-load producer (memread=0) never stalls; the forwarding unit covers it.
- Counter saturates: from `2^CNT_W-1` it stays at that value.
- Reset mid-stall: outputs clear immediately, and `stall` drops because `ID_EX_valid=0`.

## Test plan
- **Reset:** assert `rst` mid-cycle with nonzero ID/EX contents → all outputs read 0 before the next `clk` edge; `bubble_cnt=0`.
- **Pass-through:** `add x3,x1,x2`, i.e. `id_rs1=1`, `id_rs2=2`, `id_rd=3`, `id_regwr=1`, `id_pc=0x10`.
  - Response: next cycle `ID_EX_rd=3`, `ID_EX_pc=0x10`, `ID_EX_regwr=1`, `ID_EX_valid=1`, `stall=0`.
- **Load-use:** `lw x5,0(x1)` followed by `add x6,x5,x7`.
  - Response: `stall=1` for one cycle; the next ID/EX is a bubble (`ID_EX_valid=0`, `rd=0`); the following cycle holds the add with `ID_EX_rs1=5`; `bubble_cnt=1`.
- **No-stall cases:**
  - `lw x0,...` then `add x6,x0,x7` → `stall=0`.
  - `lw x5` then `addi x6,x8,1` with `id_rs2=5`, `id_uses_rs2=0` → `stall=0`.
- **Flush precedence:** `lw x5` in ID/EX and dependent `add` in ID, with `flush=1` → `stall=0`, next ID/EX is a bubble, `bubble_cnt` unchanged.
- **Counter saturation:** `CNT_W=2`, drive 5 load-use pairs → `bubble_cnt` goes 1, 2, 3, 3, 3.
